// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N output-stationary systolic MAC array.
// One start pulse produces one C = A*B:
//   - clear the PE grid
//   - stream A columns and B rows onto the west and north edges, skewed per lane
//   - wait for the array to fill and flush
//   - drain the N*N accumulators, row-major, through a valid/ready port
// Optional build macro TPU_CTRL_ACCUM_EN adds an 'accumulate' input, sampled
// with start. When it is set the clear is skipped, so C += A*B.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start; all outputs quiet
// S_CLEAR   | one-cycle synchronous clear of every PE accumulator
// S_COMPUTE | t = 0..3N-2: read operands for t<N, feed skewed edges, flush
// S_DRAIN   | d = 0..N*N-1: present C[d] on res_data until accepted
// S_DONE    | one-cycle done pulse, then back to idle
module systolic_ctrl #(
    parameter int N      = 2,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef TPU_CTRL_ACCUM_EN
    input  logic                  accumulate,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  op_rd_en,
    output logic [ADDR_W-1:0]     op_rd_addr,
    input  logic [N*WIDTH-1:0]    a_col_data,
    input  logic [N*WIDTH-1:0]    b_row_data,
    output logic [N*WIDTH-1:0]    a_edge,
    output logic [N*WIDTH-1:0]    b_edge,
    output logic                  array_clear,
    output logic [ADDR_W-1:0]     c_sel,
    input  logic [2*WIDTH-1:0]    c_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*WIDTH-1:0]    res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int LAST_T = 3 * N - 2;
    localparam int T_W    = $clog2(LAST_T + 1);

    localparam logic [T_W-1:0]    T_LAST = T_W'(LAST_T);
    localparam logic [T_W-1:0]    T_N    = T_W'(N);
    localparam logic [ADDR_W-1:0] D_LAST = ADDR_W'(N * N - 1);

    state_t            state, state_nxt;
    logic [T_W-1:0]    cyc_left;
    logic [T_W-1:0]    t_cnt;
    logic [ADDR_W-1:0] d_cnt;
    logic              rd_vld;
    logic              skip_clear;
    logic              in_compute;

`ifdef TPU_CTRL_ACCUM_EN
    assign skip_clear = accumulate;
`else
    assign skip_clear = 1'b0;
`endif

    // COMPUTE runs on a down-counter; t is recovered from it for the read address.
    assign t_cnt      = T_LAST - cyc_left;
    assign in_compute = (state == S_COMPUTE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // COMPUTE timer, drain index and the read-data-valid flag.
    // The buffer answers one cycle after a read, so rd_vld is op_rd_en delayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_left <= '0;
            d_cnt    <= '0;
            rd_vld   <= 1'b0;
        end else begin
            rd_vld <= op_rd_en;
            if (state == S_COMPUTE) begin
                if (cyc_left != '0) begin
                    cyc_left <= cyc_left - 1'b1;
                end
            end else begin
                cyc_left <= T_LAST;
            end
            if (state == S_DRAIN) begin
                if (res_ready) begin
                    d_cnt <= d_cnt + 1'b1;
                end
            end else begin
                d_cnt <= '0;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        op_rd_en    = 1'b0;
        op_rd_addr  = '0;
        array_clear = 1'b0;
        c_sel       = '0;
        res_valid   = 1'b0;
        res_data    = '0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = skip_clear ? S_COMPUTE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                array_clear = 1'b1;
                state_nxt   = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (t_cnt < T_N) begin
                    op_rd_en   = 1'b1;
                    op_rd_addr = ADDR_W'(t_cnt);
                end
                if (cyc_left == '0) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                c_sel     = d_cnt;
                res_valid = 1'b1;
                res_data  = c_data;
                if (res_ready && (d_cnt == D_LAST)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge lanes: lane i is delayed i cycles so that PE(i,j) sees A[i][k] and B[k][j] together.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] a_g, b_g;

        assign a_g = rd_vld ? a_col_data[i*WIDTH +: WIDTH] : '0;
        assign b_g = rd_vld ? b_row_data[i*WIDTH +: WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign a_edge[i*WIDTH +: WIDTH] = in_compute ? a_g : '0;
            assign b_edge[i*WIDTH +: WIDTH] = in_compute ? b_g : '0;
        end else begin : g_skew
            logic [WIDTH-1:0] a_sk [i];
            logic [WIDTH-1:0] b_sk [i];

            // Skew shift chain; idle cycles shift zeros so the lane drains clean.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) begin
                        a_sk[s] <= '0;
                        b_sk[s] <= '0;
                    end
                end else begin
                    a_sk[0] <= a_g;
                    b_sk[0] <= b_g;
                    for (int s = 1; s < i; s++) begin
                        a_sk[s] <= a_sk[s-1];
                        b_sk[s] <= b_sk[s-1];
                    end
                end
            end

            assign a_edge[i*WIDTH +: WIDTH] = in_compute ? a_sk[i-1] : '0;
            assign b_edge[i*WIDTH +: WIDTH] = in_compute ? b_sk[i-1] : '0;
        end
    end

endmodule
